// File: rtl/if_instr_buffer.sv
// if_instr_buffer
//   Instruction queue between fetch and decode. Each entry holds an
//   instruction word and its PC. The queue absorbs decode stalls and is
//   emptied on a control-flow redirect. The head entry drives the decode
//   stage outputs.
//
//   Optional feature macro: IB_BYPASS_EN
//     defined   : an incoming fetch into an empty queue is presented on the
//                 decode outputs in the same cycle. It is consumed directly
//                 unless decode stalls, in which case it is stored.
//     undefined : strict one-cycle fetch-to-decode latency. There is no
//                 combinational path from the fetch inputs to the decode
//                 outputs.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   reset        synchronous, active-high reset
//   InstrF       instruction word from instruction memory
//   PCF          PC of InstrF
//   FetchValidF  InstrF/PCF valid this cycle
//   FetchReadyF  queue can accept a push this cycle (Count < DEPTH)
//   StallD       decode holding; the head is not consumed
//   FlushD       redirect; drop all buffered and incoming instructions
//   InstrD       head instruction (NOP 0x00000013 when empty)
//   PCD          PC of the head instruction (0 when empty)
//   PCPlus4D     PCD + 4 (0 when empty)
//   InstrValidD  head entry valid
//   Count        number of occupied entries
module if_instr_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [XLEN-1:0]          InstrF,
    input  logic [XLEN-1:0]          PCF,
    input  logic                     FetchValidF,
    output logic                     FetchReadyF,
    input  logic                     StallD,
    input  logic                     FlushD,
    output logic [XLEN-1:0]          InstrD,
    output logic [XLEN-1:0]          PCD,
    output logic [XLEN-1:0]          PCPlus4D,
    output logic                     InstrValidD,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic buf_valid;
    logic bypass;
    logic push;
    logic pop_buf;

    assign buf_valid   = (count_q != '0);
    assign FetchReadyF = (count_q < CW'(DEPTH));
    assign Count       = count_q;

`ifdef IB_BYPASS_EN
    // The fetch word goes straight to decode when the queue is empty. It is
    // only stored if decode does not take it this cycle.
    assign bypass = ~buf_valid & FetchValidF & ~FlushD;
`else
    assign bypass = 1'b0;
`endif

    assign pop_buf = buf_valid & ~StallD;
    assign push    = FetchValidF & FetchReadyF & ~FlushD & ~(bypass & ~StallD);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FlushD) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_buf) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop_buf})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not cleared on reset or flush; Count alone marks validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            instr_mem_q[wr_ptr_q] <= InstrF;
            pc_mem_q[wr_ptr_q]    <= PCF;
        end
    end

    always_comb begin
        InstrValidD = 1'b0;
        InstrD      = NOP_INSTR;
        PCD         = '0;
        PCPlus4D    = '0;
        if (buf_valid) begin
            InstrValidD = 1'b1;
            InstrD      = instr_mem_q[rd_ptr_q];
            PCD         = pc_mem_q[rd_ptr_q];
            PCPlus4D    = pc_mem_q[rd_ptr_q] + XLEN'(4);
        end else if (bypass) begin
            InstrValidD = 1'b1;
            InstrD      = InstrF;
            PCD         = PCF;
            PCPlus4D    = PCF + XLEN'(4);
        end
    end

endmodule

// File: tb/tb_if_instr_buffer.sv
// tb_if_instr_buffer
//   Directed stimulus for if_instr_buffer. A queue-based reference model
//   tracks the buffered {instr, pc} pairs. The decode-side outputs are
//   compared against it on every falling edge. Literal expectations at key
//   points pin down the model itself.
module tb_if_instr_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic [XLEN-1:0]   InstrF;
    logic [XLEN-1:0]   PCF;
    logic              FetchValidF;
    logic              FetchReadyF;
    logic              StallD;
    logic              FlushD;
    logic [XLEN-1:0]   InstrD;
    logic [XLEN-1:0]   PCD;
    logic [XLEN-1:0]   PCPlus4D;
    logic              InstrValidD;
    logic [$clog2(DEPTH):0] Count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    if_instr_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .FetchValidF (FetchValidF),
        .FetchReadyF (FetchReadyF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .InstrValidD (InstrValidD),
        .Count       (Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {instr, pc}. The queue is emptied on reset
    // or flush. A push is accepted while the queue holds fewer than DEPTH
    // entries, and the front is dropped whenever decode is not stalled.
    logic [63:0] mq[$];
    bit          model_ok = 0;

    always @(posedge clk) begin
        bit do_pop, do_push;
        if (reset || FlushD) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() != 0) && !StallD;
            do_push = FetchValidF && (mq.size() < DEPTH);
`ifdef IB_BYPASS_EN
            if (mq.size() == 0 && FetchValidF && !StallD) do_push = 0;
`endif
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({InstrF, PCF});
        end
        model_ok = 1;
    end

    always @(negedge clk) begin
        logic [31:0] e_instr, e_pc, e_pc4;
        logic        e_valid;
        if (model_ok && !reset) begin
            e_valid = 0; e_instr = NOP; e_pc = 0; e_pc4 = 0;
            if (mq.size() != 0) begin
                e_valid = 1;
                e_instr = mq[0][63:32];
                e_pc    = mq[0][31:0];
                e_pc4   = e_pc + 32'd4;
            end
`ifdef IB_BYPASS_EN
            else if (FetchValidF && !FlushD) begin
                e_valid = 1; e_instr = InstrF; e_pc = PCF; e_pc4 = PCF + 32'd4;
            end
`endif
            chk("m_valid", {31'd0, InstrValidD}, {31'd0, e_valid});
            chk("m_instr", InstrD, e_instr);
            chk("m_pc",    PCD, e_pc);
            chk("m_pc4",   PCPlus4D, e_pc4);
            chk("m_count", 32'(Count), 32'(mq.size()));
            chk("m_ready", {31'd0, FetchReadyF}, {31'd0, (mq.size() < DEPTH)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        FetchValidF = 0;
        FlushD      = 0;
        #0;
    endtask

    initial begin
        reset = 1; InstrF = 0; PCF = 0; FetchValidF = 0; StallD = 0; FlushD = 0;
        step(); step();
        reset = 0;
        #1;
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_valid", {31'd0, InstrValidD}, 32'd0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pc",    PCD, 32'd0);
        chk("rst_pc4",   PCPlus4D, 32'd0);
        chk("rst_ready", {31'd0, FetchReadyF}, 32'd1);

        // Single push, one-cycle latency.
        InstrF = 32'h00A0_0093; PCF = 32'h0; FetchValidF = 1; StallD = 1;
        step();
        idle(); #1;
        chk("one_instr", InstrD, 32'h00A0_0093);
        chk("one_pc",    PCD, 32'h0);
        chk("one_pc4",   PCPlus4D, 32'h4);
        chk("one_valid", {31'd0, InstrValidD}, 32'd1);
        chk("one_count", 32'(Count), 32'd1);
        StallD = 0;
        step();
        chk("one_drain", {31'd0, InstrValidD}, 32'd0);

        // Fill under stall; the fifth push is dropped.
        StallD = 1;
        for (int i = 0; i < 5; i++) begin
            InstrF = 32'h1000_0000 | (i * 4); PCF = i * 4; FetchValidF = 1;
            step();
        end
        idle(); #1;
        chk("full_count", 32'(Count), 32'd4);
        chk("full_ready", {31'd0, FetchReadyF}, 32'd0);
        StallD = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_pc",    PCD, 32'(i * 4));
            chk("drain_instr", InstrD, 32'h1000_0000 | (i * 4));
            step();
        end
        chk("drain_empty", {31'd0, InstrValidD}, 32'd0);

        // Steady push+pop at Count=2 across pointer wrap.
        StallD = 1;
        for (int i = 0; i < 2; i++) begin
            InstrF = 32'h2000_0000 + i; PCF = 32'h100 + i * 4; FetchValidF = 1;
            step();
        end
        chk("pp_count0", 32'(Count), 32'd2);
        StallD = 0;
        for (int k = 0; k < 6; k++) begin
            InstrF = 32'h2000_0002 + k; PCF = 32'h108 + k * 4; FetchValidF = 1;
            step();
            chk("pp_count", 32'(Count), 32'd2);
            chk("pp_pc",    PCD, 32'h100 + (k + 1) * 4);
        end
        idle();
        step(); step();
        chk("pp_empty", 32'(Count), 32'd0);

        // Flush at Count=3 with an incoming fetch, decode also stalled.
        StallD = 1;
        for (int i = 0; i < 3; i++) begin
            InstrF = 32'h3000_0000 + i; PCF = 32'h200 + i * 4; FetchValidF = 1;
            step();
        end
        chk("fl_count0", 32'(Count), 32'd3);
        InstrF = 32'h3000_00FF; PCF = 32'h2FC; FetchValidF = 1; FlushD = 1;
        step();
        idle(); #1;
        chk("fl_count", 32'(Count), 32'd0);
        chk("fl_valid", {31'd0, InstrValidD}, 32'd0);
        chk("fl_instr", InstrD, NOP);
        chk("fl_pc",    PCD, 32'd0);
        step();
        chk("stall_empty", 32'(Count), 32'd0);

        // PC wrap for PCPlus4D.
        InstrF = 32'h0000_0113; PCF = 32'hFFFF_FFFC; FetchValidF = 1;
        step();
        idle(); #1;
        chk("wrap_pc",  PCD, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4D, 32'h0);

        // Reset mid-operation at Count=3 with stall and incoming fetch.
        for (int i = 0; i < 2; i++) begin
            InstrF = 32'h4000_0000 + i; PCF = 32'h400 + i * 4; FetchValidF = 1;
            step();
        end
        chk("rs_count0", 32'(Count), 32'd3);
        reset = 1; FetchValidF = 1; InstrF = 32'h4000_00FF; PCF = 32'h4FC;
        step();
        reset = 0; idle(); #1;
        chk("rs_count", 32'(Count), 32'd0);
        chk("rs_valid", {31'd0, InstrValidD}, 32'd0);
        chk("rs_instr", InstrD, NOP);
        chk("rs_pc",    PCD, 32'd0);
        chk("rs_pc4",   PCPlus4D, 32'd0);
        chk("rs_ready", {31'd0, FetchReadyF}, 32'd1);
        StallD = 0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
